// File: rtl/hop_sched_pkg.sv
// Shared types and default widths for the frequency-hop sequencer.
package hop_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    localparam int TX_BITS_WIDTH_DEF  = 128;
    localparam int NHOPS_DEF          = 16;
    localparam int HOP_IDX_WIDTH_DEF  = 4;
    localparam int DWELL_WIDTH_DEF    = 24;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/hop_sched_if.sv
// Hop-word handshake between the sequencer (master) and the scan-chain loader (slave).
interface hop_sched_if #(
    parameter int W = 128
);
    // scan_word moves on a cycle where scan_valid && scan_ready; once raised, scan_valid
    // and scan_word hold until that cycle. scan_done is a 1-cycle pulse from the loader.
    logic [W-1:0] scan_word;
    logic         scan_valid;
    logic         scan_ready;
    logic         scan_done;

    modport master (
        output scan_word,
        output scan_valid,
        input  scan_ready,
        input  scan_done
    );

    modport slave (
        input  scan_word,
        input  scan_valid,
        output scan_ready,
        output scan_done
    );
endinterface

// File: rtl/hop_sched_table.sv
// Hop configuration register file: synchronous write, combinational read.
module hop_table #(
    parameter int TX_BITS_WIDTH = 128,
    parameter int NHOPS         = 16,
    parameter int HOP_IDX_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en_i,
    input  logic [HOP_IDX_WIDTH-1:0] wr_addr_i,
    input  logic [TX_BITS_WIDTH-1:0] wr_data_i,
    input  logic [HOP_IDX_WIDTH-1:0] rd_addr_i,
    output logic [TX_BITS_WIDTH-1:0] rd_data_o
);
    localparam bit FULL = (NHOPS == (1 << HOP_IDX_WIDTH));

    logic [TX_BITS_WIDTH-1:0] mem_q [NHOPS];
    logic                     wr_ok;

    // Indices past the populated entries are silently dropped.
    generate
        if (FULL) begin : g_full
            assign wr_ok = 1'b1;
        end else begin : g_part
            assign wr_ok = (wr_addr_i < HOP_IDX_WIDTH'(NHOPS));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NHOPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/hop_sched.sv
// Frequency-hop sequencer: hands table words to the scan loader one at a time, waits
// for the load to finish, dwells, then advances (wrapping, or stopping after one pass).
module hop_sched
    import hop_sched_pkg::*;
#(
    parameter int TX_BITS_WIDTH  = TX_BITS_WIDTH_DEF,
    parameter int NHOPS          = NHOPS_DEF,
    parameter int HOP_IDX_WIDTH  = HOP_IDX_WIDTH_DEF,
    parameter int DWELL_WIDTH    = DWELL_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_wr_en,
    input  logic [HOP_IDX_WIDTH-1:0] cfg_wr_addr,
    input  logic [TX_BITS_WIDTH-1:0] cfg_wr_data,
    input  logic [HOP_IDX_WIDTH:0]   num_hops,
    input  logic [DWELL_WIDTH-1:0]   dwell,
    input  logic                     single_pass,
    input  logic                     start,
    input  logic                     stop,
    hop_sched_if.master              scan,
    output logic                     hop_strobe,
    output logic [HOP_IDX_WIDTH-1:0] hop_idx,
    output logic [15:0]              hop_cnt,
    output logic                     busy,
    output logic                     err_timeout,
    output state_t                   dbg_state
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOP_IDX_WIDTH:0] NHOPS_MAX = (HOP_IDX_WIDTH + 1)'(NHOPS);

    state_t                   state_q;
    logic [HOP_IDX_WIDTH:0]   nhops_q;
    logic [DWELL_WIDTH-1:0]   dwell_q;
    logic [DWELL_WIDTH-1:0]   dwell_cnt_q;
    logic [TMO_W-1:0]         tmo_cnt_q;
    logic                     single_q;
    logic                     stop_pend_q;
    logic [TX_BITS_WIDTH-1:0] word_q;
    logic                     valid_q;
    logic                     strobe_q;
    logic [HOP_IDX_WIDTH-1:0] idx_q;
    logic [15:0]              cnt_q;
    logic                     err_q;

    logic [HOP_IDX_WIDTH:0]   nhops_d;
    logic [DWELL_WIDTH-1:0]   dwell_d;
    logic [HOP_IDX_WIDTH-1:0] last_idx;
    logic [HOP_IDX_WIDTH-1:0] next_idx;
    logic                     is_last;
    logic                     dwell_done;
    logic [HOP_IDX_WIDTH-1:0] rd_addr;
    logic [TX_BITS_WIDTH-1:0] rd_data;

    hop_table #(
        .TX_BITS_WIDTH (TX_BITS_WIDTH),
        .NHOPS         (NHOPS),
        .HOP_IDX_WIDTH (HOP_IDX_WIDTH)
    ) u_table (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (cfg_wr_en),
        .wr_addr_i (cfg_wr_addr),
        .wr_data_i (cfg_wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Run parameters are clamped once, at start, so the FSM only ever sees legal values.
    always_comb begin
        nhops_d = num_hops;
        if (num_hops == '0) begin
            nhops_d = (HOP_IDX_WIDTH + 1)'(1);
        end else if (num_hops > NHOPS_MAX) begin
            nhops_d = NHOPS_MAX;
        end
        dwell_d = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
    end

    assign last_idx   = HOP_IDX_WIDTH'(nhops_q - (HOP_IDX_WIDTH + 1)'(1));
    assign is_last    = (idx_q == last_idx);
    assign next_idx   = is_last ? '0 : idx_q + HOP_IDX_WIDTH'(1);
    assign dwell_done = (dwell_cnt_q <= DWELL_WIDTH'(1));

    // The single read port serves hop 0 at start and the following hop at the dwell boundary.
    assign rd_addr = (state_q == ST_DWELL) ? next_idx : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            nhops_q     <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            single_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        nhops_q  <= nhops_d;
                        dwell_q  <= dwell_d;
                        single_q <= single_pass;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        word_q   <= rd_data;
                        valid_q  <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (valid_q && scan.scan_ready) begin
                        valid_q   <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (scan.scan_done) begin
                        strobe_q    <= 1'b1;
                        cnt_q       <= cnt_q + 16'd1;
                        dwell_cnt_q <= dwell_q;
                        state_q     <= ST_DWELL;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_q       <= 1'b1;
                        stop_pend_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_DWELL: begin
                    if (dwell_done) begin
                        if (stop_pend_q || stop || (single_q && is_last)) begin
                            stop_pend_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            idx_q   <= next_idx;
                            word_q  <= rd_data;
                            valid_q <= 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - DWELL_WIDTH'(1);
                        if (stop) begin
                            stop_pend_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan.scan_word  = word_q;
    assign scan.scan_valid = valid_q;
    assign hop_strobe      = strobe_q;
    assign hop_idx         = idx_q;
    assign hop_cnt         = cnt_q;
    assign err_timeout     = err_q;
    assign busy            = (state_q != ST_IDLE);
    assign dbg_state       = state_q;

endmodule
